simon_sequencer: RTL

Game-sequencing controller for the Simon core. Each round it samples the free-running 7-bit LFSR, appends one colour to an on-chip sequence memory, and plays the whole sequence on the four lamps with fixed on/off timing. It then checks the player's button presses against the stored sequence. It sits between the LFSR (`rand_out`), the debounced button pulses, and the lamp/score outputs.

---
 rtl/simon_pkg.sv | 27 ++
 rtl/simon_sequencer_phase_timer.sv | 34 +++
 rtl/simon_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon game sequencer.
//   state_t          : sequencer FSM states
//   colour_t         : 2-bit lamp/button colour code
//   colour_to_onehot : colour code -> one-hot lamp/button vector
package simon_pkg;

  localparam int unsigned NUM_COLOURS = 4;

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    SHOW_ON,
    SHOW_OFF,
    INPUT,
    PAUSE,
    LOSE,
    WIN
  } state_t;

  typedef logic [1:0] colour_t;

  // Colour c drives lamp/button bit c.
  function automatic logic [NUM_COLOURS-1:0] colour_to_onehot(input colour_t c);
    return NUM_COLOURS'(4'b0001 << c);
  endfunction

endpackage

// File: rtl/simon_sequencer_phase_timer.sv
// Loadable down-counter used to time lamp on/off phases.
//   clk, reset_n : clock and synchronous active-low reset
//   load         : load load_val this cycle (takes priority over counting)
//   load_val     : number of cycles the current phase should last (>= 1)
//   expired      : high for exactly one cycle, the last cycle of the phase
module phase_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  // expired is registered: it rises together with count reaching 1.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (load) begin
      count   <= load_val;
      expired <= (load_val == W'(1));
    end else if (count != '0) begin
      count   <= count - W'(1);
      expired <= (count == W'(2));
    end else begin
      expired <= 1'b0;
    end
  end

endmodule

// File: rtl/simon_sequencer.sv
// Simon game sequencer: grows a random colour sequence one step per round,
// plays it back on the lamps, and checks the player's presses against it.
//   clk, reset_n  : clock and synchronous active-low reset
//   start         : one-cycle pulse, starts a new game from any state
//   rand_in       : LFSR output, bits [1:0] pick the new colour
//   btn           : one-cycle button press pulses, bit i = colour i
//   led           : one-hot lamp during playback, else 0
//   accept_input  : waiting for player presses
//   level         : current sequence length
//   game_over/win : sticky end-of-game flags
module simon_sequencer
  import simon_pkg::*;
#(
  parameter int unsigned MAX_LEN    = 32,
  parameter int unsigned ON_CYCLES  = 25_000_000,
  parameter int unsigned GAP_CYCLES = 12_500_000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [6:0]                rand_in,
  input  logic [3:0]                btn,
  output logic [3:0]                led,
  output logic                      accept_input,
  output logic [$clog2(MAX_LEN):0]  level,
  output logic                      game_over,
  output logic                      win
);

  localparam int unsigned IW   = $clog2(MAX_LEN);
  localparam int unsigned LW   = IW + 1;
  localparam int unsigned TMAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  state_t        state, state_n;
  logic [LW-1:0] len, len_n;
  logic [IW-1:0] idx, idx_n;
  colour_t       mem [MAX_LEN];

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_expired;

  logic          last_step;
  logic          btn_ok;
  colour_t       show_colour;
  logic [3:0]    led_n;
  logic          accept_n, game_over_n, win_n;

  logic          unused_rand;
  assign unused_rand = ^rand_in[6:2];

  phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  // Sequence memory: not reset, written only while adding a colour.
  always_ff @(posedge clk) begin
    if (state == ADD && !start) begin
      mem[len[IW-1:0]] <= colour_t'(rand_in[1:0]);
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      len          <= '0;
      idx          <= '0;
      led          <= '0;
      accept_input <= 1'b0;
      game_over    <= 1'b0;
      win          <= 1'b0;
    end else begin
      state        <= state_n;
      len          <= len_n;
      idx          <= idx_n;
      led          <= led_n;
      accept_input <= accept_n;
      game_over    <= game_over_n;
      win          <= win_n;
    end
  end

  assign level = len;

  // Next-state logic and next-cycle output decode.
  always_comb begin
    state_n  = state;
    len_n    = len;
    idx_n    = idx;
    tmr_load = 1'b0;
    tmr_val  = '0;

    last_step = ({1'b0, idx} == (len - LW'(1)));
    btn_ok    = (btn == colour_to_onehot(mem[idx]));

    if (start) begin
      state_n = ADD;
      len_n   = '0;
      idx_n   = '0;
    end else begin
      case (state)
        IDLE: ;
        ADD: begin
          len_n    = len + LW'(1);
          idx_n    = '0;
          tmr_load = 1'b1;
          tmr_val  = TW'(ON_CYCLES);
          state_n  = SHOW_ON;
        end
        SHOW_ON: begin
          if (tmr_expired) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(GAP_CYCLES);
            state_n  = SHOW_OFF;
          end
        end
        SHOW_OFF: begin
          if (tmr_expired) begin
            if (last_step) begin
              idx_n   = '0;
              state_n = INPUT;
            end else begin
              idx_n    = idx + IW'(1);
              tmr_load = 1'b1;
              tmr_val  = TW'(ON_CYCLES);
              state_n  = SHOW_ON;
            end
          end
        end
        INPUT: begin
          if (btn != '0) begin
            // Exact match with a one-hot code also rejects multi-hot presses.
            if (!btn_ok) begin
              state_n = LOSE;
            end else if (last_step && len == LW'(MAX_LEN)) begin
              state_n = WIN;
            end else if (last_step) begin
              tmr_load = 1'b1;
              tmr_val  = TW'(GAP_CYCLES);
              state_n  = PAUSE;
            end else begin
              idx_n = idx + IW'(1);
            end
          end
        end
        PAUSE: begin
          if (tmr_expired) begin
            state_n = ADD;
          end
        end
        LOSE: ;
        WIN:  ;
        default: state_n = IDLE;
      endcase
    end

    // The first colour of a round may be written at the same edge it is shown.
    if (state == ADD && !start && idx_n == len[IW-1:0]) begin
      show_colour = colour_t'(rand_in[1:0]);
    end else begin
      show_colour = mem[idx_n];
    end

    led_n       = (state_n == SHOW_ON) ? colour_to_onehot(show_colour) : 4'b0000;
    accept_n    = (state_n == INPUT);
    game_over_n = (state_n == LOSE);
    win_n       = (state_n == WIN);
  end

endmodule
